// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter.
// Holds the baud-select encodings, the transmit FSM state type and a
// helper that turns a clock frequency and baud select into a bit period.
package uart_pkg;

    localparam logic [1:0] RATE_2400  = 2'b00;
    localparam logic [1:0] RATE_4800  = 2'b01;
    localparam logic [1:0] RATE_9600  = 2'b10;
    localparam logic [1:0] RATE_19200 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Bit period in clock cycles (integer truncation) for a baud select.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [1:0] rate);
        int unsigned baud;
        case (rate)
            RATE_2400:  baud = 2400;
            RATE_4800:  baud = 4800;
            RATE_9600:  baud = 9600;
            default:    baud = 19200;
        endcase
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..div-1 and flags the last cycle of each bit.
// Ports: clk, rst (sync, active high), restart (zero the count on the next
// edge), div (bit period in cycles), bit_end (high during the cycle whose
// count equals div-1).
module uart_bit_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [CNT_W-1:0] div,
    output logic             bit_end
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart wins, otherwise wrap at div-1.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == div - CNT_W'(1))) begin
            cnt_d = '0;
        end
    end

    // bit_end is registered from the next count so it aligns with cnt_q == div-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_end <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_end <= (cnt_d == div - CNT_W'(1));
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-client round-robin arbitrated UART transmitter (8N1, per-client baud).
// Ports: clk, rst (sync, active high); req[1:0] level requests; data0/data1
// bytes and rate0/rate1 baud selects per client; grant/done one-cycle pulses
// per client; busy (not IDLE); cur_rate (baud of frame in progress, held
// when idle); tx serial line (idle high).
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [1:0] rate0,
    input  logic [1:0] rate1,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       busy,
    output logic [1:0] cur_rate,
    output logic       tx
);

    localparam int unsigned DIV_MAX = baud_div(CLK_HZ, RATE_2400);
    // +1 so div itself fits even when DIV_MAX is a power of two.
    localparam int unsigned CNT_W   = $clog2(DIV_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_2400  = CNT_W'(baud_div(CLK_HZ, RATE_2400));
    localparam logic [CNT_W-1:0] DIV_4800  = CNT_W'(baud_div(CLK_HZ, RATE_4800));
    localparam logic [CNT_W-1:0] DIV_9600  = CNT_W'(baud_div(CLK_HZ, RATE_9600));
    localparam logic [CNT_W-1:0] DIV_19200 = CNT_W'(baud_div(CLK_HZ, RATE_19200));

    tx_state_t        state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             client_q, client_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       rate_d;
    logic [1:0]       grant_d, done_d;
    logic             tx_d;
    logic             win;
    logic             restart_c;
    logic             bit_end;
    logic [CNT_W-1:0] div_c;

    // Bit period of the latched rate.
    always_comb begin
        case (cur_rate)
            RATE_2400: div_c = DIV_2400;
            RATE_4800: div_c = DIV_4800;
            RATE_9600: div_c = DIV_9600;
            default:   div_c = DIV_19200;
        endcase
    end

    uart_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_c),
        .div     (div_c),
        .bit_end (bit_end)
    );

    // Next-state, arbitration and next-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        client_d  = client_q;
        data_d    = data_q;
        rate_d    = cur_rate;
        grant_d   = 2'b00;
        done_d    = 2'b00;
        restart_c = 1'b0;
        win       = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    // Both requesting: the client not served last wins.
                    win       = (req == 2'b11) ? ~last_q : req[1];
                    state_d   = ST_START;
                    client_d  = win;
                    last_d    = win;
                    data_d    = win ? data1 : data0;
                    rate_d    = win ? rate1 : rate0;
                    grant_d   = win ? 2'b10 : 2'b01;
                    restart_c = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = client_q ? 2'b10 : 2'b01;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx is registered from the state being entered so it lines up with it.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = data_d[idx_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            last_q   <= 1'b1;
            client_q <= 1'b0;
            data_q   <= 8'h00;
            cur_rate <= 2'b10;
            grant    <= 2'b00;
            done     <= 2'b00;
            busy     <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            client_q <= client_d;
            data_q   <= data_d;
            cur_rate <= rate_d;
            grant    <= grant_d;
            done     <= done_d;
            busy     <= (state_d != ST_IDLE);
            tx       <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, is the system clock frequency in Hz and is used to compute the bit divisors.
REQ-002 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port req, input, 2 bits: level request from client 0 and client 1.
REQ-005 Port data0 / data1, input, 8 bits each: byte to send for each client.
REQ-006 Port rate0 / rate1, input, 2 bits each: baud select per client; 00=2400, 01=4800, 10=9600, 11=19200.
REQ-007 Port grant, output, 2 bits: one-cycle pulse when a client's byte and rate are latched.
REQ-008 Port done, output, 2 bits: one-cycle pulse when that client's frame completes.
REQ-009 Port busy, output, 1 bit: high in every state except IDLE.
REQ-010 Port cur_rate, output, 2 bits: baud select of the frame in progress; holds its last value when IDLE.
REQ-011 Port tx, output, 1 bit: serial line, idle high.

Function
REQ-012 Bit period DIV(rate) = CLK_HZ / baud, with integer truncation, computed at elaboration for each of the four rates.
REQ-013 The bit counter width is sized for DIV(2400); it counts 0..DIV-1, and the bit ends on the cycle the count equals DIV-1.
REQ-014 The FSM has four states: IDLE, START, DATA, STOP.
REQ-015 In IDLE with no request pending, the block stays in IDLE.
- With a request pending, it takes the IDLE->START transition on the next edge.
- On that same edge it latches the winner's data and rate and pulses that client's grant bit.
REQ-016 Arbitration is round-robin using a last-served pointer.
- With one request, that client wins.
- With both requests, the client not last served wins.
- The pointer updates on grant.
REQ-017 tx is 0 for one bit period in START.
REQ-018 DATA sends 8 bits, LSB first, for one bit period each, tracked by a 3-bit index.
REQ-019 tx is 1 for one bit period in STOP; tx is also 1 in IDLE.
REQ-020 The STOP->IDLE transition happens on the edge where the stop bit ends; done for the latched client pulses in the cycle following that edge.
REQ-021 A frame occupies exactly 10*DIV cycles from entering START to re-entering IDLE.
- Back-to-back frames are separated by exactly one IDLE cycle.
REQ-022 Changes to req, dataX or rateX while busy are ignored; the frame uses only the latched values.
REQ-023 A client that keeps req high after grant is served again.
- It is served when it next wins arbitration, so it alternates with the other client if both are held high.
REQ-024 grant and done are never asserted in the same cycle for the same client, and never for both clients at once.

Reset
REQ-025 While rst is high at a clock edge, the following values are forced:
- state=IDLE, tx=1, busy=0, grant=0, done=0, cur_rate=2'b10;
- last-served pointer=client 1, bit counter=0, bit index=0.
REQ-026 Reset asserted mid-frame abandons the frame.
- tx returns to 1 on the next edge.
- No done pulse is issued for the abandoned frame.
REQ-027 After reset, client 0 wins the first simultaneous request.

Structure
REQ-028 Package uart_pkg holds the following shared items:
- the rate encodings;
- the FSM state enum;
- a function returning DIV for a rate given CLK_HZ.
REQ-029 The bit-period counter is one sub-module, uart_bit_timer.
- Inputs: clk, rst, restart, div.
- Output: a one-cycle bit_end pulse.
- uart_tx_arb instantiates it once.

Verification
REQ-030 Benches shall run with CLK_HZ=192000, so DIV = 80 / 40 / 20 / 10 for rates 00 / 01 / 10 / 11.
REQ-031 Single frame: req=01, data0=8'hA5, rate0=11.
- grant=01 pulse, then tx = 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles.
- done=01 pulse; busy high for 100 cycles.
REQ-032 Contention: req=11 held continuously after reset.
- Grants are 01, 10, 01, 10, alternating.
- cur_rate tracks the rate of each granted client.
REQ-033 Rate latch: rate1=00 at grant, rate1 changed to 11 mid-frame.
- All bits of that frame remain 80 cycles; the next frame uses 10.
REQ-034 Reset mid-frame: rst pulsed during DATA bit 3.
- tx=1 and busy=0 the next cycle; no done pulse.
- The next request is served with a full-length frame.
REQ-035 Back-to-back: req0 held high with rate 10.
- Exactly one IDLE cycle with tx=1 between STOP end and the next START.
- Each frame is 200 cycles.
